// File: rtl/modsub_u_pkg.sv
// Shared definitions for the modular subtractor: pipeline configuration record
// and latency helper used by modsub_u and its instantiators.
package modsub_u_pkg;

  // One bit per optional register stage, in pipeline order.
  typedef struct packed {
    logic ff_in;
    logic ff_sub;
    logic ff_out;
  } modsub_u_params_t;

  function automatic int modsub_u_lat(input modsub_u_params_t p);
    return int'(p.ff_in) + int'(p.ff_sub) + int'(p.ff_out);
  endfunction

endpackage

// File: rtl/modsub_u_pipe_stage.sv
// Optional pipeline register: loads d on adv when EN != 0, otherwise a plain
// wire from d to q.
module pipe_stage #(
  parameter int EN = 1,
  parameter int W  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (EN != 0) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (adv) begin
          q <= d;
        end
      end
    end else begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, adv};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/modsub_u.sv
// Modular subtractor T = (A - B) mod q with q = {qH, 0..0, 1}, up to three
// optional pipeline registers. Define MODSUB_TAG_EN to carry a sideband tag.
module modsub_u
  import modsub_u_pkg::*;
#(
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 17,
  parameter int FF_IN  = 1,
  parameter int FF_SUB = 1,
  parameter int FF_OUT = 1,
  parameter int TAGW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  input  logic [LOGQ-1:0]  A,
  input  logic [LOGQ-1:0]  B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LOGQ-1:0]  T,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MODSUB_TAG_EN
  ,
  input  logic [TAGW-1:0]  in_tag,
  output logic [TAGW-1:0]  out_tag
`endif
);

  localparam modsub_u_params_t CFG = '{
    ff_in:  (FF_IN != 0),
    ff_sub: (FF_SUB != 0),
    ff_out: (FF_OUT != 0)
  };
  localparam int LAT = modsub_u_lat(CFG);
  localparam int R   = LOGQ - LOGQH;

  generate
    if (TAGW < 1 || LOGQ < 2) begin : g_bad_param
      $error("modsub_u: TAGW must be >= 1 and LOGQ >= 2");
    end
  endgenerate

  logic [LOGQ-1:0] q_mod;

  generate
    if (R > 0) begin : g_q_split
      assign q_mod = (LOGQ'(qH) << R) | LOGQ'(1);
    end else begin : g_q_whole
      assign q_mod = qH[LOGQ-1:0];
    end
  endgenerate

  // Handshake: an input is taken when in_valid && in_ready, a result leaves when
  // out_valid && out_ready. All stages move together whenever the output slot
  // is empty or being drained; in_ready never looks at in_valid.
  logic advance;
  assign advance = out_ready || !out_valid;

  generate
    if (LAT == 0) begin : g_comb_ready
      assign in_ready = out_ready;
    end else begin : g_pipe_ready
      assign in_ready = advance;
    end
  endgenerate

  logic            s1_v;
  logic [LOGQ-1:0] s1_a;
  logic [LOGQ-1:0] s1_b;

  pipe_stage #(.EN(FF_IN), .W(1 + 2 * LOGQ)) u_stage_in (
    .clk (clk),
    .rst (rst),
    .adv (advance),
    .d   ({in_valid, A, B}),
    .q   ({s1_v, s1_a, s1_b})
  );

  // Extra top bit of the difference is the borrow.
  logic [LOGQ:0] diff;
  assign diff = {1'b0, s1_a} - {1'b0, s1_b};

  logic          s2_v;
  logic [LOGQ:0] s2_d;

  pipe_stage #(.EN(FF_SUB), .W(2 + LOGQ)) u_stage_sub (
    .clk (clk),
    .rst (rst),
    .adv (advance),
    .d   ({s1_v, diff}),
    .q   ({s2_v, s2_d})
  );

  logic            borrow;
  logic [LOGQ-1:0] res;
  assign borrow = s2_d[LOGQ];
  assign res    = borrow ? (s2_d[LOGQ-1:0] + q_mod) : s2_d[LOGQ-1:0];

  logic            s3_v;
  logic [LOGQ-1:0] s3_t;

  pipe_stage #(.EN(FF_OUT), .W(1 + LOGQ)) u_stage_out (
    .clk (clk),
    .rst (rst),
    .adv (advance),
    .d   ({s2_v, res}),
    .q   ({s3_v, s3_t})
  );

  assign out_valid = s3_v;
  assign T         = s3_t;

`ifdef MODSUB_TAG_EN
  // Tag rides alongside the data through identically configured stages.
  logic [TAGW-1:0] tag_s1;
  logic [TAGW-1:0] tag_s2;

  pipe_stage #(.EN(FF_IN), .W(TAGW)) u_tag_in (
    .clk (clk),
    .rst (rst),
    .adv (advance),
    .d   (in_tag),
    .q   (tag_s1)
  );

  pipe_stage #(.EN(FF_SUB), .W(TAGW)) u_tag_sub (
    .clk (clk),
    .rst (rst),
    .adv (advance),
    .d   (tag_s1),
    .q   (tag_s2)
  );

  pipe_stage #(.EN(FF_OUT), .W(TAGW)) u_tag_out (
    .clk (clk),
    .rst (rst),
    .adv (advance),
    .d   (tag_s2),
    .q   (out_tag)
  );
`endif

endmodule

// File: doc/modsub_u.md
MODSUB_U -- requirements
Module: modsub_u

Interface
REQ-001 SHALL have parameter LOGQ, default 64, modulus/operand width in bits.
REQ-002 SHALL have parameter LOGQH, default 17, width of modulus high part qH.
REQ-003 SHALL have parameter FF_IN, default 1, 1 = register operands at the input.
REQ-004 SHALL have parameter FF_SUB, default 1, 1 = register the raw difference and borrow.
REQ-005 SHALL have parameter FF_OUT, default 1, 1 = register the result.
REQ-006 SHALL have parameter TAGW, default 8, sideband tag width, used only with MODSUB_TAG_EN.
REQ-007 SHALL have port clk, input, 1 bit, the single clock, rising-edge active.
REQ-008 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port qH, input, LOGQH bits, modulus high part, quasi-static.
REQ-010 SHALL have ports A and B, input, LOGQ bits each, operands in [0,q).
REQ-011 SHALL have port in_valid, input, 1 bit, A/B valid.
REQ-012 SHALL have port in_ready, output, 1 bit, pipeline accepts this cycle.
REQ-013 SHALL have port T, output, LOGQ bits, (A-B) mod q.
REQ-014 SHALL have port out_valid, output, 1 bit, T valid.
REQ-015 SHALL have port out_ready, input, 1 bit, downstream accepts T.
REQ-016 SHALL have ports in_tag (input) and out_tag (output), TAGW bits, present only under MODSUB_TAG_EN.

Function
REQ-017 SHALL form modulus q = {qH, (R-1) zeros, 1} with R = LOGQ-LOGQH when R>0, else q = qH.
REQ-018 SHALL compute D = A-B at LOGQ+1 bits; borrow = D[LOGQ].
REQ-019 SHALL output T = (D+q) mod 2^LOGQ when borrow=1, else D[LOGQ-1:0]; inputs outside [0,q) give undefined T.
REQ-020 SHALL use stage order: FF_IN reg, subtract, FF_SUB reg (D, borrow), add-back/select, FF_OUT reg.
REQ-021 SHALL have latency LAT = FF_IN+FF_SUB+FF_OUT cycles from accepted input to out_valid.
REQ-022 SHALL, with LAT=0, be combinational: out_valid=in_valid, in_ready=out_ready.
REQ-023 SHALL accept an input only on the cycle in which in_valid && in_ready.
REQ-024 SHALL complete a transfer only on the cycle in which out_valid && out_ready.
REQ-025 SHALL use global stall: advance = out_ready || !out_valid; all stages shift together when advance=1, else all hold.
REQ-026 SHALL drive in_ready = advance, with no combinational path from in_valid to in_ready.
REQ-027 SHALL keep a valid bit per stage; a stage holding an invalid slot shifts as a bubble (no bubble collapsing).
REQ-028 SHALL hold T, out_tag and out_valid stable while out_valid=1 and out_ready=0.
REQ-029 SHALL sustain 1 result/cycle with out_ready held at 1.

Reset
REQ-030 SHALL clear all stage valid bits and all data/tag registers to 0 asynchronously on rst=1.
REQ-031 SHALL, while rst=1, drive out_valid=0, T=0 and in_ready=1 (when LAT>0).
REQ-032 SHALL discard in-flight operations on mid-operation reset; the first post-reset output is from the first post-reset input.

Configuration
REQ-033 SHALL, with MODSUB_TAG_EN defined, carry in_tag through the same valid-qualified registers so that out_tag aligns with T.
REQ-034 SHALL, without MODSUB_TAG_EN, omit the tag ports and tag registers entirely.

Structure
REQ-035 SHALL place typedef modsub_u_params_t {FF_IN, FF_SUB, FF_OUT} and function modsub_u_lat() in the shared monty include alongside the correction_u definitions.
REQ-036 SHALL implement each optional register as an instance of sub-module pipe_stage (params EN, W; ports clk, rst, adv, d, q), which bypasses when EN=0.

Verification
REQ-037 SHALL cover, with LOGQ=16, LOGQH=8, qH=0xFF (q=0xFF01), defaults: A=5, B=3 -> T=0x0002 after 3 cycles.
REQ-038 SHALL cover A=3, B=5 -> T=0xFEFF (borrow path).
REQ-039 SHALL cover A=B=0xFF00 -> T=0; A=0, B=0xFF00 -> T=0x0001.
REQ-040 SHALL cover back-to-back inputs 1..6 with B=0 while out_ready is held 0 for cycles 4-6 -> in_ready=0 during the stall, outputs 1..6 in order with no loss or duplication.
REQ-041 SHALL cover rst asserted with 3 ops in flight -> out_valid=0 immediately; the next output is the first post-reset op.
REQ-042 SHALL cover FF_IN=FF_SUB=FF_OUT=0 with MODSUB_TAG_EN: tag 0xA5 with A=3, B=5 -> same cycle T=0xFEFF, out_tag=0xA5.
